// File: rtl/verdict_serializer.sv
// Captures per-cycle monitor verdicts into a record FIFO and streams each record as a
// header word followed by its active values. VERDICT_TIMESTAMP_EN enables the cycle timestamp.
module verdict_serializer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] output_0,
    input  logic [63:0] output_1,
    input  logic [63:0] output_2,
    input  logic [63:0] output_3,
    input  logic        output_0_aktv,
    input  logic        output_1_aktv,
    input  logic        output_2_aktv,
    input  logic        output_3_aktv,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, VALUE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [3:0]      rem_q, rem_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_count_q, drop_count_d;

    logic [3:0]      cap_mask;
    logic [255:0]    cap_vals;
    logic            push_req, push, pop, drop, full, hs;
    logic [3:0]      head_mask, nxt_mask, rem_after;
    logic [255:0]    head_vals;
    logic [31:0]     head_ts, nxt_ts;
    logic [1:0]      first_idx;
    logic [63:0]     sel_word;

    logic [3:0]      mask_mem [FIFO_DEPTH];
    logic [255:0]    val_mem  [FIFO_DEPTH];

    assign cap_mask = {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv};
    assign cap_vals = {output_3, output_2, output_1, output_0};

    assign full     = (count_q == DEPTH_C);
    assign hs       = out_valid_q && out_ready;
    assign pop      = hs && out_last_q;
    assign push_req = en && (cap_mask != 4'b0000);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q] <= cap_mask;
            val_mem[wr_ptr_q]  <= cap_vals;
        end
    end

    assign rd_ptr_inc = rd_ptr_q + PW'(1);
    assign head_mask  = mask_mem[rd_ptr_q];
    assign head_vals  = val_mem[rd_ptr_q];
    // With one record left and a capture on the pop edge, the next head is still being written.
    assign nxt_mask   = (count_q == CW'(1)) ? cap_mask : mask_mem[rd_ptr_inc];

`ifdef VERDICT_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_mem [FIFO_DEPTH];

    always_comb begin
        ts_d = en ? ts_q + 32'd1 : ts_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_d;
    end

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr_q] <= ts_q;
    end

    assign head_ts = ts_mem[rd_ptr_q];
    assign nxt_ts  = (count_q == CW'(1)) ? ts_q : ts_mem[rd_ptr_inc];
`else
    assign head_ts = '0;
    assign nxt_ts  = '0;
`endif

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_inc : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        overflow_d   = overflow_q | drop;
        drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    end

    // Lowest remaining mask bit selects the next value word.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rem_q[i]) first_idx = 2'(i);
        end
        rem_after = rem_q & ~(4'b0001 << first_idx);
        case (first_idx)
            2'd0:    sel_word = head_vals[63:0];
            2'd1:    sel_word = head_vals[127:64];
            2'd2:    sel_word = head_vals[191:128];
            default: sel_word = head_vals[255:192];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = HEADER;
                    out_valid_d = 1'b1;
                    out_data_d  = {head_mask, 28'h0, head_ts};
                    out_last_d  = 1'b0;
                    rem_d       = head_mask;
                end
            end
            HEADER: begin
                if (hs) begin
                    state_d    = VALUE;
                    out_data_d = sel_word;
                    rem_d      = rem_after;
                    out_last_d = (rem_after == 4'b0000);
                end
            end
            VALUE: begin
                if (hs && out_last_q) begin
                    if (count_d != '0) begin
                        state_d    = HEADER;
                        out_data_d = {nxt_mask, 28'h0, nxt_ts};
                        out_last_d = 1'b0;
                        rem_d      = nxt_mask;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        rem_d       = 4'b0000;
                    end
                end else if (hs) begin
                    out_data_d = sel_word;
                    rem_d      = rem_after;
                    out_last_d = (rem_after == 4'b0000);
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
                rem_d       = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            rem_q        <= 4'b0000;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            rem_q        <= rem_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_verdict_serializer.sv
// Scoreboard bench for verdict_serializer: driver queues expected words, a negedge monitor checks them.
module tb_verdict_serializer;
`ifdef VERDICT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, out_ready;
    logic [63:0] output_0, output_1, output_2, output_3;
    logic        output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv;
    logic [63:0] out_data;
    logic        out_valid, out_last, overflow;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    verdict_serializer #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(output_0), .output_1(output_1), .output_2(output_2), .output_3(output_3),
        .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
        .output_2_aktv(output_2_aktv), .output_3_aktv(output_3_aktv),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .overflow(overflow), .drop_count(drop_count)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tb_ts = 32'h0;
    logic [65:0] exp_q [$];          // {is_header, last, data}
    logic [31:0] hdr_ts_hist [$];

    // Reference cycle counter: edges with en=1 since reset release.
    always @(posedge clk) tb_ts <= !rst ? 32'h0 : (en ? tb_ts + 32'd1 : tb_ts);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d, input bit accept,
                           output logic [31:0] ts_used);
        logic [63:0] vv [4];
        logic        lastb;
        vv[0] = a; vv[1] = b; vv[2] = c; vv[3] = d;
        ts_used = TS_EN ? tb_ts : 32'h0;
        {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv} = m;
        output_0 = a; output_1 = b; output_2 = c; output_3 = d;
        if (accept) begin
            exp_q.push_back({1'b1, 1'b0, m, 28'h0, ts_used});
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    lastb = ((m >> (i + 1)) == 4'b0000);
                    exp_q.push_back({1'b0, lastb, vv[i]});
                end
            end
        end
        $display("capture mask=%b v=%0h,%0h,%0h,%0h ts=%0d accept=%0b", m, a, b, c, d, ts_used, accept);
        tick();
        {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv} = 4'b0000;
    endtask

    task automatic wait_drain(input string name, input bit toggle);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            n++;
        end
        chk({"drain_", name}, 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;
        tick();
    endtask

    // Monitor: one line per transferred word, plus stability checks while stalled.
    initial begin
        logic        stall_pending = 1'b0;
        logic [64:0] stall_word = '0;
        logic [65:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_pending = 1'b0;
            end else begin
                if (stall_pending) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_data", out_data, stall_word[63:0]);
                    chk("stall_last", 64'(out_last), 64'(stall_word[64]));
                end
                stall_pending = out_valid && !out_ready;
                stall_word    = {out_last, out_data};
                if (out_valid && out_ready) begin
                    $display("word data=%h last=%0b", out_data, out_last);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%h required=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", out_data, e[63:0]);
                        chk("word_last", 64'(out_last), 64'(e[64]));
                        if (e[65]) hdr_ts_hist.push_back(out_data[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ts_a, ts_b;
        int          n, seen;
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        output_0 = '0; output_1 = '0; output_2 = '0; output_3 = '0;
        {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv} = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_last", 64'(out_last), 64'd0);
        chk("reset_data", out_data, 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b1;

        // Single event with 2-cycle header latency.
        capture(4'b0101, 64'd1, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFD, 64'hBEEF, 1'b1, ts_a);
        chk("lat_bubble", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_header", out_data, {4'b0101, 28'h0, ts_a});
        wait_drain("single", 1'b0);

        // Backpressure, ready toggling every cycle.
        out_ready = 1'b0;
        capture(4'b1111, 64'd10, 64'd11, 64'd12, 64'd13, 1'b1, ts_a);
        wait_drain("backpressure", 1'b1);

        // Back-to-back records: second capture lands on the pop edge of the first.
        capture(4'b0001, 64'h21, 64'h0, 64'h0, 64'h0, 1'b1, ts_a);
        tick();
        tick();
        capture(4'b0010, 64'h0, 64'h22, 64'h0, 64'h0, 1'b1, ts_b);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_header", out_data, {4'b0010, 28'h0, ts_b});
        wait_drain("b2b", 1'b0);

        // Timestamp delta over 7 enabled edges.
        hdr_ts_hist.delete();
        capture(4'b0001, 64'h31, 64'h0, 64'h0, 64'h0, 1'b1, ts_a);
        repeat (6) tick();
        capture(4'b1000, 64'h0, 64'h0, 64'h0, 64'h32, 1'b1, ts_b);
        wait_drain("timestamp", 1'b0);
        chk("ts_count", 64'(hdr_ts_hist.size()), 64'd2);
        if (hdr_ts_hist.size() == 2)
            chk("ts_delta", 64'(hdr_ts_hist[1] - hdr_ts_hist[0]), TS_EN ? 64'd7 : 64'd0);

        // Overflow: 10 captures into an 8-deep FIFO with the sink stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            capture(4'b0001, 64'(300 + i), 64'h0, 64'h0, 64'h0, i < 8, ts_a);
        chk("ovf_drop_count", 64'(drop_count), 64'd2);
        chk("ovf_flag", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (exp_q.size() != 0 && n < 100);
        chk("ovf_drain_cycles", 64'(n), 64'd16);
        chk("ovf_idle_after", 64'(out_valid), 64'd0);

        // Full FIFO with a capture on the out_last handshake edge.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            capture(4'b0001, 64'(400 + i), 64'h0, 64'h0, 64'h0, 1'b1, ts_a);
        out_ready = 1'b1;
        tick();
        capture(4'b0010, 64'h0, 64'd500, 64'h0, 64'h0, 1'b1, ts_a);
        chk("fp_no_drop", 64'(drop_count), 64'd2);
        wait_drain("full_pop", 1'b0);
        chk("fp_drop_after", 64'(drop_count), 64'd2);

        // Reset after the header handshake of a record.
        capture(4'b1111, 64'd1, 64'd2, 64'd3, 64'd4, 1'b1, ts_a);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_last", 64'(out_last), 64'd0);
        chk("rst_mid_data", out_data, 64'd0);
        chk("rst_mid_drop", 64'(drop_count), 64'd0);
        chk("rst_mid_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        hdr_ts_hist.delete();
        tick();
        tick();
        rst = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rst_fifo_empty", 64'(seen), 64'd0);
        capture(4'b0001, 64'h77, 64'h0, 64'h0, 64'h0, 1'b1, ts_a);
        wait_drain("after_reset", 1'b0);
        chk("rst_hdr_count", 64'(hdr_ts_hist.size()), 64'd1);
        if (hdr_ts_hist.size() == 1)
            chk("rst_fresh_ts", 64'(hdr_ts_hist[0]), TS_EN ? 64'd5 : 64'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
